// File: rtl/cmd_frame_parser_if.sv
// Byte stream in, command and acknowledge handshakes out of the frame parser.
// master is the parser side; slave is the UART / executor / transmitter side.
interface cmd_frame_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] cmd_lmotor;
  logic [7:0] cmd_rmotor;
  logic [7:0] cmd_dur;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ack_req;
  logic [7:0] ack_code;
  logic       ack_taken;
  logic [7:0] err_count;

  modport master (
    input  rx_byte,
    input  rx_valid,
    input  cmd_ready,
    input  ack_taken,
    output cmd_lmotor,
    output cmd_rmotor,
    output cmd_dur,
    output cmd_valid,
    output ack_req,
    output ack_code,
    output err_count
  );

  modport slave (
    output rx_byte,
    output rx_valid,
    output cmd_ready,
    output ack_taken,
    input  cmd_lmotor,
    input  cmd_rmotor,
    input  cmd_dur,
    input  cmd_valid,
    input  ack_req,
    input  ack_code,
    input  err_count
  );
endinterface

// File: rtl/cmd_frame_parser.sv
// Parses SYNC,lmotor,rmotor,dur,chk frames into a motor command,
// offers it on a valid/ready handshake and queues an A/N acknowledge.
module cmd_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [15:0] GAP_TIMEOUT = 16'd40000
) (
  input logic                clk,
  input logic                resetTrigger,
  cmd_frame_parser_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LM,
    RM,
    DUR,
    CHK,
    HOLD,
    ACKW
  } state_t;

  localparam logic [7:0]  ACK_OK   = 8'h41;
  localparam logic [7:0]  ACK_BAD  = 8'h4E;
  localparam logic [15:0] GAP_LAST = GAP_TIMEOUT - 16'd1;

  state_t      state_q, state_d;
  logic [7:0]  lm_sh_q, lm_sh_d;
  logic [7:0]  rm_sh_q, rm_sh_d;
  logic [7:0]  dur_sh_q, dur_sh_d;
  logic [7:0]  cmd_lm_q, cmd_lm_d;
  logic [7:0]  cmd_rm_q, cmd_rm_d;
  logic [7:0]  cmd_dur_q, cmd_dur_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        ack_req_q, ack_req_d;
  logic [7:0]  ack_code_q, ack_code_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] gap_q, gap_d;
  logic        err_inc;
  logic        in_frame;
  logic        gap_expired;
  logic [7:0]  sum;

  always_comb begin
    state_d     = state_q;
    lm_sh_d     = lm_sh_q;
    rm_sh_d     = rm_sh_q;
    dur_sh_d    = dur_sh_q;
    cmd_lm_d    = cmd_lm_q;
    cmd_rm_d    = cmd_rm_q;
    cmd_dur_d   = cmd_dur_q;
    cmd_valid_d = cmd_valid_q;
    ack_req_d   = ack_req_q;
    ack_code_d  = ack_code_q;
    err_d       = err_q;
    err_inc     = 1'b0;
    sum         = lm_sh_q + rm_sh_q + dur_sh_q;
    in_frame    = state_q inside {LM, RM, DUR, CHK};
    gap_d       = in_frame ? gap_q + 16'd1 : 16'd0;
    // A byte landing on the last allowed cycle wins over the timeout.
    gap_expired = in_frame && !bus.rx_valid && (gap_q >= GAP_LAST);
    if (bus.rx_valid) gap_d = 16'd0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
          state_d = LM;
          gap_d   = 16'd0;
        end
      end
      LM: begin
        if (bus.rx_valid) begin
          lm_sh_d = bus.rx_byte;
          state_d = RM;
        end
      end
      RM: begin
        if (bus.rx_valid) begin
          rm_sh_d = bus.rx_byte;
          state_d = DUR;
        end
      end
      DUR: begin
        if (bus.rx_valid) begin
          dur_sh_d = bus.rx_byte;
          state_d  = CHK;
        end
      end
      CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == sum) begin
            cmd_lm_d    = lm_sh_q;
            cmd_rm_d    = rm_sh_q;
            cmd_dur_d   = dur_sh_q;
            cmd_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            ack_code_d = ACK_BAD;
            ack_req_d  = 1'b1;
            err_inc    = 1'b1;
            state_d    = ACKW;
          end
        end
      end
      HOLD: begin
        if (bus.rx_valid) err_inc = 1'b1;
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          ack_code_d  = ACK_OK;
          ack_req_d   = 1'b1;
          state_d     = ACKW;
        end
      end
      ACKW: begin
        if (bus.rx_valid) err_inc = 1'b1;
        if (bus.ack_taken) begin
          ack_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gap_expired) begin
      state_d = IDLE;
      gap_d   = 16'd0;
      err_inc = 1'b1;
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge resetTrigger) begin
    if (resetTrigger) begin
      state_q     <= IDLE;
      lm_sh_q     <= 8'h00;
      rm_sh_q     <= 8'h00;
      dur_sh_q    <= 8'h00;
      cmd_lm_q    <= 8'h00;
      cmd_rm_q    <= 8'h00;
      cmd_dur_q   <= 8'h00;
      cmd_valid_q <= 1'b0;
      ack_req_q   <= 1'b0;
      ack_code_q  <= 8'h00;
      err_q       <= 8'h00;
      gap_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      lm_sh_q     <= lm_sh_d;
      rm_sh_q     <= rm_sh_d;
      dur_sh_q    <= dur_sh_d;
      cmd_lm_q    <= cmd_lm_d;
      cmd_rm_q    <= cmd_rm_d;
      cmd_dur_q   <= cmd_dur_d;
      cmd_valid_q <= cmd_valid_d;
      ack_req_q   <= ack_req_d;
      ack_code_q  <= ack_code_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.cmd_lmotor = cmd_lm_q;
  assign bus.cmd_rmotor = cmd_rm_q;
  assign bus.cmd_dur    = cmd_dur_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.ack_req    = ack_req_q;
  assign bus.ack_code   = ack_code_q;
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: expected commands/acks queued
// at stimulus time and compared when the handshakes complete.
module tb_cmd_frame_parser;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         GAP  = 50;

  typedef struct packed {
    logic [7:0] lm;
    logic [7:0] rm;
    logic [7:0] dur;
  } cmd_t;

  logic clk = 1'b0;
  logic resetTrigger;

  cmd_frame_parser_if bus ();

  cmd_frame_parser #(
    .SYNC_BYTE  (SYNC),
    .GAP_TIMEOUT(16'(GAP))
  ) dut (
    .clk         (clk),
    .resetTrigger(resetTrigger),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  cmd_t       cmd_q[$];
  logic [7:0] ack_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_err  = 0;

  // Scoreboard side: pop on the cycle each handshake completes.
  always @(negedge clk) begin : mon
    cmd_t       ec;
    logic [7:0] ea;
    if (resetTrigger === 1'b0) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        n_checks++;
        if (cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_xfer unexpected: got %h/%h/%h, required none",
                   bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur);
        end else begin
          ec = cmd_q.pop_front();
          if ({bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur} !== ec) begin
            n_fail++;
            $display("FAIL cmd_xfer got %h/%h/%h required %h/%h/%h",
                     bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur,
                     ec.lm, ec.rm, ec.dur);
          end
        end
      end
      if (bus.ack_req === 1'b1 && bus.ack_taken === 1'b1) begin
        n_checks++;
        if (ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_xfer unexpected: got %h, required none",
                   bus.ack_code);
        end else begin
          ea = ack_q.pop_front();
          if (bus.ack_code !== ea) begin
            n_fail++;
            $display("FAIL ack_xfer got %h required %h", bus.ack_code, ea);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic bump_err(input int n);
    exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
  endtask

  task automatic send_frame(input logic [7:0] lm, input logic [7:0] rm,
                            input logic [7:0] dur, input logic [7:0] chk);
    logic [7:0] s;
    s = lm + rm + dur;
    if (chk == s) begin
      cmd_q.push_back(cmd_t'{lm: lm, rm: rm, dur: dur});
      ack_q.push_back(8'h41);
    end else begin
      ack_q.push_back(8'h4E);
      bump_err(1);
    end
    send_byte(SYNC);
    send_byte(lm);
    send_byte(rm);
    send_byte(dur);
    send_byte(chk);
  endtask

  task automatic do_ack(input string tag);
    int w = 0;
    while (bus.ack_req !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    n_checks++;
    if (bus.ack_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ack_wait got ack_req=%b required 1", tag, bus.ack_req);
    end else begin
      bus.ack_taken = 1'b1;
      tick(1);
      bus.ack_taken = 1'b0;
      n_checks++;
      if (bus.ack_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ack_drop got %b required 0", tag, bus.ack_req);
      end
    end
  endtask

  task automatic test_reset;
    resetTrigger  = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.cmd_ready = 1'b0;
    bus.ack_taken = 1'b0;
    tick(3);
    n_checks++;
    if ({bus.cmd_valid, bus.ack_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_flags got %b%b required 00", bus.cmd_valid, bus.ack_req);
    end
    n_checks++;
    if ({bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur, bus.ack_code,
         bus.err_count} !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_bytes got %h %h %h %h %h required zeros",
               bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur, bus.ack_code,
               bus.err_count);
    end
    resetTrigger = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.cmd_valid, bus.ack_req, bus.err_count} !== 10'h0) begin
      n_fail++;
      $display("FAIL rst_release got v=%b a=%b e=%h required 0/0/00",
               bus.cmd_valid, bus.ack_req, bus.err_count);
    end
  endtask

  task automatic test_good_frame;
    bus.cmd_ready = 1'b1;
    send_frame(8'h85, 8'h10, 8'h40, 8'hD5);
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.ack_req !== 1'b0) begin
      n_fail++;
      $display("FAIL good_lat got v=%b a=%b required 1/0",
               bus.cmd_valid, bus.ack_req);
    end
    tick(1);
    n_checks++;
    if (bus.cmd_valid !== 1'b0 || bus.ack_req !== 1'b1 ||
        bus.ack_code !== 8'h41) begin
      n_fail++;
      $display("FAIL good_ack got v=%b a=%b code=%h required 0/1/41",
               bus.cmd_valid, bus.ack_req, bus.ack_code);
    end
    tick(3);
    n_checks++;
    if (bus.ack_req !== 1'b1 || bus.ack_code !== 8'h41) begin
      n_fail++;
      $display("FAIL good_ack_hold got a=%b code=%h required 1/41",
               bus.ack_req, bus.ack_code);
    end
    do_ack("good");
    n_checks++;
    if ({bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur} !== 24'h851040) begin
      n_fail++;
      $display("FAIL good_fields_kept got %h%h%h required 851040",
               bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur);
    end
  endtask

  task automatic test_bad_checksum;
    send_frame(8'h01, 8'h02, 8'h03, 8'h07);
    n_checks++;
    if (bus.cmd_valid !== 1'b0 || bus.ack_req !== 1'b1 ||
        bus.ack_code !== 8'h4E) begin
      n_fail++;
      $display("FAIL bad_chk got v=%b a=%b code=%h required 0/1/4E",
               bus.cmd_valid, bus.ack_req, bus.ack_code);
    end
    n_checks++;
    if (bus.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL bad_err got %h required %h", bus.err_count, 8'(exp_err));
    end
    n_checks++;
    if ({bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur} !== 24'h851040) begin
      n_fail++;
      $display("FAIL bad_fields got %h%h%h required 851040",
               bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur);
    end
    do_ack("bad");
  endtask

  task automatic test_garbage;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(SYNC, SYNC, SYNC, 8'hEF);
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL garbage got v=%b e=%h required 1/%h",
               bus.cmd_valid, bus.err_count, 8'(exp_err));
    end
    do_ack("garbage");
  endtask

  task automatic test_gap_timeout;
    send_byte(SYNC);
    send_byte(8'h11);
    tick(GAP - 1);
    n_checks++;
    if (bus.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL gap_early got %h required %h", bus.err_count, 8'(exp_err));
    end
    tick(1);
    bump_err(1);
    n_checks++;
    if (bus.err_count !== 8'(exp_err) || bus.ack_req !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_expire got e=%h a=%b required %h/0",
               bus.err_count, bus.ack_req, 8'(exp_err));
    end
    send_frame(8'h22, 8'h33, 8'h44, 8'h99);
    do_ack("gap_after");
    send_byte(SYNC);
    send_byte(8'h01);
    tick(GAP - 1);
    send_byte(8'h02);
    tick(GAP - 1);
    send_byte(8'h03);
    cmd_q.push_back(cmd_t'{lm: 8'h01, rm: 8'h02, dur: 8'h03});
    ack_q.push_back(8'h41);
    send_byte(8'h06);
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL gap_edge got v=%b e=%h required 1/%h",
               bus.cmd_valid, bus.err_count, 8'(exp_err));
    end
    do_ack("gap_edge");
  endtask

  task automatic test_backpressure;
    logic stable = 1'b1;
    bus.cmd_ready = 1'b0;
    send_frame(8'h7F, 8'h80, 8'h01, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (i == 30 || i == 60) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = SYNC;
      end
      tick(1);
      bus.rx_valid = 1'b0;
      if (bus.cmd_valid !== 1'b1 ||
          {bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur} !== 24'h7F8001)
        stable = 1'b0;
    end
    bump_err(2);
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable got %b required 1", stable);
    end
    n_checks++;
    if (bus.err_count !== 8'(exp_err) || bus.ack_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_err got e=%h a=%b required %h/0",
               bus.err_count, bus.ack_req, 8'(exp_err));
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    n_checks++;
    if (bus.cmd_valid !== 1'b0 || bus.ack_req !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_xfer got v=%b a=%b required 0/1",
               bus.cmd_valid, bus.ack_req);
    end
    do_ack("bp");
  endtask

  task automatic test_saturation;
    bus.cmd_ready = 1'b0;
    send_frame(8'h01, 8'h01, 8'h01, 8'h03);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h00;
    tick(300);
    bus.rx_valid = 1'b0;
    bump_err(300);
    n_checks++;
    if (bus.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL sat_err got %h required %h", bus.err_count, 8'(exp_err));
    end
    bus.cmd_ready = 1'b1;
    do_ack("sat");
  endtask

  task automatic pulse_reset(input string tag);
    resetTrigger = 1'b1;
    #2;
    n_checks++;
    if ({bus.cmd_valid, bus.ack_req} !== 2'b00 ||
        {bus.cmd_lmotor, bus.cmd_rmotor, bus.cmd_dur, bus.ack_code,
         bus.err_count} !== 40'h0) begin
      n_fail++;
      $display("FAIL %s got v=%b a=%b %h %h %h %h %h required all zero", tag,
               bus.cmd_valid, bus.ack_req, bus.cmd_lmotor, bus.cmd_rmotor,
               bus.cmd_dur, bus.ack_code, bus.err_count);
    end
    @(posedge clk);
    #1;
    resetTrigger = 1'b0;
    exp_err = 0;
    ack_q.delete();
  endtask

  task automatic test_reset_midframe;
    bus.cmd_ready = 1'b1;
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_reset("rst_mid");
    send_byte(8'h33);
    send_byte(8'h66);
    n_checks++;
    if (bus.ack_req !== 1'b0 || bus.err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_lost got a=%b e=%h required 0/00",
               bus.ack_req, bus.err_count);
    end
    send_frame(8'h05, 8'h06, 8'h07, 8'h12);
    tick(2);
    n_checks++;
    if (bus.ack_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ackw got %b required 1", bus.ack_req);
    end
    pulse_reset("rst_ackw");
    send_frame(8'h10, 8'h20, 8'h30, 8'h60);
    n_checks++;
    if (bus.cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_next got %b required 1", bus.cmd_valid);
    end
    do_ack("rst_next");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage();
    test_gap_timeout();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    tick(2);
    n_checks++;
    if (cmd_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got cmd=%0d ack=%0d required 0/0",
               cmd_q.size(), ack_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
